// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm unit: FSM state encoding and BCD wrap limits
// of the alarm-time fields.
package alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RING     = 2'd2,
        SNOOZE   = 2'd3
    } alarm_state_e;

    localparam logic [6:0] MIN_MAX = 7'h59;
    localparam logic [4:0] HR_MAX  = 5'h11;

endpackage

// File: rtl/bcd_wrap_inc.sv
// Combinational BCD +1 for a {tens, units} packed field, wrapping to zero
// once the field reaches MAX_VAL.
module bcd_wrap_inc #(
    parameter int                TENS_W  = 3,
    parameter logic [TENS_W+3:0] MAX_VAL = '0
) (
    input  logic [TENS_W+3:0] cur,
    output logic [TENS_W+3:0] result
);

    logic [TENS_W-1:0] tens;
    logic [3:0]        units;

    assign tens  = cur[TENS_W+3:4];
    assign units = cur[3:0];

    always_comb begin
        if (cur == MAX_VAL) begin
            result = '0;
        end else if (units == 4'd9) begin
            result = {tens + TENS_W'(1), 4'h0};
        end else begin
            result = {tens, units + 4'd1};
        end
    end

endmodule

// File: rtl/alarm_unit.sv
// Alarm time register, match compare against the running BCD time, and the
// ring / snooze / timeout sequencer driving the buzzer.
module alarm_unit
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int CNT_W          = $clog2(((RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S) + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [6:0] sec,
    input  logic [6:0] min,
    input  logic [4:0] hr,
    input  logic       arm,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hr,
    input  logic       snooze,
    input  logic       ack,
    output logic [6:0] alm_min,
    output logic [4:0] alm_hr,
    output logic       ringing,
    output logic       buzz,
    output logic [1:0] state
);

    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIMEOUT_S - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_S - 1);

    alarm_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             buzz_d;
    logic             match;
    logic             edit_en;
    logic [6:0]       min_inc;
    logic [4:0]       hr_inc;

    bcd_wrap_inc #(.TENS_W(3), .MAX_VAL(MIN_MAX)) u_min_inc (
        .cur    (alm_min),
        .result (min_inc)
    );

    bcd_wrap_inc #(.TENS_W(1), .MAX_VAL(HR_MAX)) u_hr_inc (
        .cur    (alm_hr),
        .result (hr_inc)
    );

    // Compare uses the registered alarm time, so a same-cycle edit cannot affect it.
    assign match   = sec_tick && (sec == 7'h00) && (min == alm_min) && (hr == alm_hr);
    assign edit_en = set_mode && ((state_q == DISARMED) || (state_q == ARMED));
    assign state   = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!arm) begin
            state_d = DISARMED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DISARMED: begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end
                ARMED: begin
                    if (match) begin
                        state_d = RING;
                        cnt_d   = '0;
                    end
                end
                RING: begin
                    if (ack) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end else if (snooze) begin
                        state_d = SNOOZE;
                        cnt_d   = '0;
                    end else if (sec_tick) begin
                        if (cnt_q == RING_LAST) begin
                            state_d = ARMED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (ack) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end else if (sec_tick) begin
                        if (cnt_q == SNOOZE_LAST) begin
                            state_d = RING;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = DISARMED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Buzzer starts low on RING entry and toggles per second while ringing.
    always_comb begin
        buzz_d = 1'b0;
        if ((state_d == RING) && (state_q == RING)) begin
            buzz_d = sec_tick ? ~buzz : buzz;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DISARMED;
            cnt_q   <= '0;
            ringing <= 1'b0;
            buzz    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ringing <= (state_d == RING);
            buzz    <= buzz_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alm_min <= 7'h00;
            alm_hr  <= 5'h00;
        end else if (edit_en) begin
            if (inc_min) alm_min <= min_inc;
            if (inc_hr)  alm_hr  <= hr_inc;
        end
    end

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: table of edit/arm vectors plus hand-written
// ring, snooze, timeout and reset sequences with hand-computed expectations.
module tb_alarm_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick, arm, set_mode, inc_min, inc_hr, snooze, ack;
    logic [6:0] sec, min;
    logic [4:0] hr;
    logic [6:0] alm_min;
    logic [4:0] alm_hr;
    logic       ringing, buzz;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       arm;
        logic       set_mode;
        logic       inc_min;
        logic       inc_hr;
        logic [6:0] exp_min;
        logic [4:0] exp_hr;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[8];

    alarm_unit dut (
        .clk      (clk),
        .rst      (rst),
        .sec_tick (sec_tick),
        .sec      (sec),
        .min      (min),
        .hr       (hr),
        .arm      (arm),
        .set_mode (set_mode),
        .inc_min  (inc_min),
        .inc_hr   (inc_hr),
        .snooze   (snooze),
        .ack      (ack),
        .alm_min  (alm_min),
        .alm_hr   (alm_hr),
        .ringing  (ringing),
        .buzz     (buzz),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive pulses for one clock edge; returns 1 time unit after the edge.
    task automatic step(input logic t, input logic im, input logic ih, input logic sn, input logic ak);
        sec_tick = t;
        inc_min  = im;
        inc_hr   = ih;
        snooze   = sn;
        ack      = ak;
        @(posedge clk);
        #1;
        sec_tick = 1'b0;
        inc_min  = 1'b0;
        inc_hr   = 1'b0;
        snooze   = 1'b0;
        ack      = 1'b0;
    endtask

    task automatic tick(input logic [6:0] s, input logic [6:0] m, input logic [4:0] h);
        sec = s;
        min = m;
        hr  = h;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [1:0] st, input logic rg, input logic bz);
        check({name, ".state"}, 32'(state), 32'(st));
        check({name, ".ringing"}, 32'(ringing), 32'(rg));
        check({name, ".buzz"}, 32'(buzz), 32'(bz));
    endtask

    initial begin
        rst = 1'b1;
        sec_tick = 1'b0; arm = 1'b0; set_mode = 1'b0;
        inc_min = 1'b0; inc_hr = 1'b0; snooze = 1'b0; ack = 1'b0;
        sec = 7'h00; min = 7'h00; hr = 5'h00;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'h01, 5'h00, 2'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 7'h01, 5'h01, 2'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 7'h02, 5'h02, 2'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'h02, 5'h02, 2'd0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'h02, 5'h02, 2'd1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 7'h02, 5'h03, 2'd1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h02, 5'h03, 2'd0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 7'h03, 5'h04, 2'd0};

        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 2'd0, 1'b0, 1'b0);
        check("reset.alm_min", 32'(alm_min), 32'h00);
        check("reset.alm_hr", 32'(alm_hr), 32'h00);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            arm      = vecs[i].arm;
            set_mode = vecs[i].set_mode;
            step(1'b0, vecs[i].inc_min, vecs[i].inc_hr, 1'b0, 1'b0);
            check($sformatf("vec%0d.alm_min", i), 32'(alm_min), 32'(vecs[i].exp_min));
            check($sformatf("vec%0d.alm_hr", i), 32'(alm_hr), 32'(vecs[i].exp_hr));
            check($sformatf("vec%0d.state", i), 32'(state), 32'(vecs[i].exp_state));
        end

        // Minute and hour wrap sweeps from 00:00.
        arm = 1'b0;
        set_mode = 1'b0;
        do_reset();
        set_mode = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            int v;
            v = i % 60;
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("min_sweep%0d", i), 32'(alm_min), 32'((v / 10) * 16 + (v % 10)));
        end
        check("min_sweep.alm_hr", 32'(alm_hr), 32'h00);
        for (int i = 1; i <= 12; i++) begin
            int v;
            v = i % 12;
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check($sformatf("hr_sweep%0d", i), 32'(alm_hr), 32'((v / 10) * 16 + (v % 10)));
        end
        check("hr_sweep.alm_min", 32'(alm_min), 32'h00);

        // Set alarm to 07:30.
        repeat (7) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (30) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_mode = 1'b0;
        check("set.alm_hr", 32'(alm_hr), 32'h07);
        check("set.alm_min", 32'(alm_min), 32'h30);

        // Matching time while disarmed does nothing.
        tick(7'h00, 7'h30, 5'h07);
        check_out("disarmed_match", 2'd0, 1'b0, 1'b0);

        arm = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("armed", 2'd1, 1'b0, 1'b0);
        tick(7'h59, 7'h29, 5'h07);
        check_out("pre_match", 2'd1, 1'b0, 1'b0);
        tick(7'h00, 7'h30, 5'h07);
        check_out("match", 2'd2, 1'b1, 1'b0);

        // 59 ticks keep ringing with buzz toggling; the 60th times out.
        for (int k = 1; k <= 59; k++) begin
            tick(7'h01, 7'h30, 5'h07);
            check_out($sformatf("ring_tick%0d", k), 2'd2, 1'b1, 1'(k % 2));
            if (k == 10) begin
                set_mode = 1'b1;
                step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                set_mode = 1'b0;
                check("ring_edit.alm_min", 32'(alm_min), 32'h30);
                check("ring_edit.alm_hr", 32'(alm_hr), 32'h07);
                check("ring_edit.buzz", 32'(buzz), 32'(0));
            end
        end
        tick(7'h02, 7'h30, 5'h07);
        check_out("ring_timeout", 2'd1, 1'b0, 1'b0);

        // Snooze: 299 ticks stay in SNOOZE, the 300th rings again.
        tick(7'h00, 7'h30, 5'h07);
        check_out("match2", 2'd2, 1'b1, 1'b0);
        tick(7'h01, 7'h30, 5'h07);
        check("match2.buzz_on", 32'(buzz), 32'(1));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_out("snooze", 2'd3, 1'b0, 1'b0);
        for (int k = 1; k <= 299; k++) begin
            tick(7'h00, 7'h30, 5'h07);
            if (k == 150 || k == 299) begin
                check_out($sformatf("snooze_tick%0d", k), 2'd3, 1'b0, 1'b0);
            end
        end
        tick(7'h01, 7'h31, 5'h07);
        check_out("snooze_expire", 2'd2, 1'b1, 1'b0);
        tick(7'h02, 7'h31, 5'h07);
        check_out("rering_tick", 2'd2, 1'b1, 1'b1);

        // ack beats snooze.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_out("ack_snooze", 2'd1, 1'b0, 1'b0);

        // ack in SNOOZE returns to ARMED.
        tick(7'h00, 7'h30, 5'h07);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_out("snooze3", 2'd3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out("snooze_ack", 2'd1, 1'b0, 1'b0);

        // Dropping arm in SNOOZE disarms next cycle.
        tick(7'h00, 7'h30, 5'h07);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick(7'h05, 7'h30, 5'h07);
        check_out("snooze4", 2'd3, 1'b0, 1'b0);
        arm = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("snooze_disarm", 2'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-RING, checked between clock edges.
        arm = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(7'h00, 7'h30, 5'h07);
        tick(7'h01, 7'h30, 5'h07);
        check_out("pre_reset", 2'd2, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_reset", 2'd0, 1'b0, 1'b0);
        check("async_reset.alm_min", 32'(alm_min), 32'h00);
        check("async_reset.alm_hr", 32'(alm_hr), 32'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alarm_unit.md
Name: alarm_unit

Overview:
- Downstream consumer of the seconds/minutes/hours timer chain (mod60/mod60/mod12, BCD-packed counts).
- Holds a user-set alarm time (HH:MM) and compares it against the running time.
- Sequences ring / snooze / timeout and drives a buzzer output plus alarm-time values for the HEX display mux.
- Runs on the system clock; time advances are qualified by a one-cycle `sec_tick` enable.

Parameters:
- `RING_TIMEOUT_S`, 60, seconds of ringing before automatic return to ARMED.
- `SNOOZE_S`, 300, seconds spent in SNOOZE before ringing again.
- `CNT_W`, $clog2(max(`RING_TIMEOUT_S`, `SNOOZE_S`)+1), width of the shared seconds counter.

Ports:
- `clk`, in, 1, system clock.
- `rst`, in, 1, asynchronous active-high reset.
- `sec_tick`, in, 1, one-cycle pulse in the cycle the time inputs first show the new second.
- `sec`, in, 7, seconds BCD: [6:4] tens, [3:0] units (00..59).
- `min`, in, 7, minutes BCD, same packing (00..59).
- `hr`, in, 5, hours BCD: [4] tens, [3:0] units (00..11).
- `arm`, in, 1, level switch; 1 = alarm enabled.
- `set_mode`, in, 1, level; 1 = inc buttons edit the alarm time.
- `inc_min`, in, 1, debounced single-cycle pulse.
- `inc_hr`, in, 1, debounced single-cycle pulse.
- `snooze`, in, 1, single-cycle pulse.
- `ack`, in, 1, single-cycle pulse; stops ringing.
- `alm_min`, out, 7, alarm minutes BCD.
- `alm_hr`, out, 5, alarm hours BCD.
- `ringing`, out, 1, high in RING.
- `buzz`, out, 1, audible output.
- `state`, out, 2, current FSM state for debug/LED.

Behaviour:
- **Reset** (async, `rst`=1): `alm_min`=7'h00, `alm_hr`=5'h00, state=DISARMED, `ringing`=0, `buzz`=0, counter=0. All registers update on rising `clk` only after `rst` deasserts.
- **States:** DISARMED=0, ARMED=1, RING=2, SNOOZE=3.
- **Match:** `match` = `sec_tick` & (`sec`==0) & (`min`==`alm_min`) & (`hr`==`alm_hr`), combinational on the current registered alarm values.
- **Transitions (priority top to bottom):**
  - `arm`=0 in any state -> DISARMED next cycle; counter cleared; `buzz`=0.
  - DISARMED & `arm`=1 -> ARMED.
  - ARMED & `match` -> RING; counter cleared.
  - RING & `ack` -> ARMED. `ack` beats `snooze` when both are asserted in the same cycle.
  - RING & `snooze` -> SNOOZE; counter cleared.
  - RING & `sec_tick` & counter==`RING_TIMEOUT_S`-1 -> ARMED; else counter++ on `sec_tick`.
  - SNOOZE & `ack` -> ARMED.
  - SNOOZE & `sec_tick` & counter==`SNOOZE_S`-1 -> RING; counter cleared; else counter++ on `sec_tick`.
  - `match` in SNOOZE or RING is ignored.
- **Latency:** state changes one clock after the qualifying input; `ringing` is registered and equals (state==RING).
- **`buzz`:**
  - Registered.
  - Cleared on entry to RING, then toggles on every `sec_tick` while in RING. This gives a 1 s on / 1 s off pattern.
  - Forced to 0 in all other states.
- **Alarm edit:**
  - Accepted only when `set_mode`=1 and state is DISARMED or ARMED; ignored in RING/SNOOZE.
  - `inc_min`: BCD +1; units 9 -> 0 with tens+1; 59 -> 00. No carry into hours.
  - `inc_hr`: BCD +1; 09 -> 10 ({1,4'h0}); 11 -> 00.
  - `inc_min` and `inc_hr` in the same cycle both apply.
  - An edit that coincides with `match` does not affect that cycle's compare; the compare uses the pre-edit values.
- **Input legality:** out-of-range inputs (e.g. `sec` units >9) are not produced by the timer chain. There is no detection; the compare is a plain equality.

Decomposition:
- **Shared package `alarm_pkg`:**
  - State encoding constants (DISARMED/ARMED/RING/SNOOZE).
  - BCD limit constants: MIN_MAX=7'h59, HR_MAX=5'h11 (i.e. {1,4'h1}).
- **Sub-module `bcd_wrap_inc`:**
  - Parameterised tens-width and max value.
  - Combinational +1 with wrap.
  - Instantiated twice, once for minutes and once for hours.
- FSM and counter stay in `alarm_unit`.

Test Plan:
- Reset mid-RING -> `ringing`=0, `buzz`=0, `alm_min`=00, `alm_hr`=00, `state`=0 immediately, without a clock edge.
- `set_mode`=1, 60 `inc_min` pulses from 00 -> sequence 01..59 then 00, `alm_hr` unchanged. 12 `inc_hr` pulses -> 01..09,10,11,00.
- Alarm 07:30, `arm`=1, drive time 07:29:59 then 07:30:00 with `sec_tick` -> `ringing`=1 next cycle. `buzz` toggles on each subsequent `sec_tick`. After 60 ticks -> ARMED, `buzz`=0.
- RING, then `snooze` pulse -> SNOOZE, `buzz`=0. After 300 `sec_tick` -> RING again. `ack` and `snooze` in the same cycle in RING -> ARMED.
- 07:30:00 `sec_tick` while `arm`=0 -> stays DISARMED. `inc_min` during RING -> `alm_min` unchanged. `arm` dropped during SNOOZE -> DISARMED next cycle.
